seq_restoring_divider: RTL and testbench



---
 rtl/seq_restoring_divider.sv | 139 +++++++++++++
 tb/tb_seq_restoring_divider.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider.
// Unsigned WIDTH-bit division producing one quotient bit per clock.
// A division by zero completes on the accepting edge with
// quotient = all ones and remainder = dividend.
// A normal division takes exactly WIDTH cycles in RUN, then holds its
// result in DONE until the next accepted start.

module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    // The counter must hold values up to WIDTH without wrapping.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;
    logic [WIDTH:0]   r_rem;      // partial remainder, one guard bit
    logic [WIDTH-1:0] r_quo;      // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] r_divisor;
    logic [CW-1:0]    r_count;

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_trial_neg;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic             w_accept;
    logic             w_last;

    // Restoring step: shift {R,Q} left, trial-subtract the divisor,
    // keep the difference only if it did not go negative.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no
        // path through the block can leave a latch behind.
        w_shift     = '0;
        w_trial     = '0;
        w_trial_neg = 1'b0;
        w_rem_next  = '0;
        w_quo_next  = '0;

        w_shift     = {r_rem, r_quo[WIDTH-1]};
        w_trial     = w_shift - {2'b00, r_divisor};
        w_trial_neg = w_trial[WIDTH+1];
        w_rem_next  = w_trial_neg ? w_shift[WIDTH:0] : w_trial[WIDTH:0];
        w_quo_next  = {r_quo[WIDTH-2:0], ~w_trial_neg};
    end

    // Start is only honoured outside RUN; the last RUN step is at count WIDTH-1.
    always_comb begin
        w_accept = start && (r_state != S_RUN);
        w_last   = (r_count == CW'(WIDTH - 1));
    end

    // Control FSM with datapath registers and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register here is cleared by reset, including the
            // datapath, because the outputs must read zero during reset.
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_divisor  <= '0;
            r_count    <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so that every
            // right-hand side reads the value from before this edge.
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_divisor <= divisor;
                        r_count   <= '0;
                        if (divisor == '0) begin
                            // Divide by zero resolves immediately, busy stays low.
                            r_state    <= S_DONE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_div_zero <= 1'b1;
                            r_quo      <= '1;
                            r_rem      <= {1'b0, dividend};
                        end else begin
                            r_state    <= S_RUN;
                            r_busy     <= 1'b1;
                            r_done     <= 1'b0;
                            r_div_zero <= 1'b0;
                            r_quo      <= dividend;
                            r_rem      <= '0;
                        end
                    end
                end

                S_RUN: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign div_zero  = r_div_zero;
    assign quotient  = r_quo;
    assign remainder = r_rem[WIDTH-1:0];

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Testbench for seq_restoring_divider (WIDTH=4).
// Directed cases, an ignored mid-run start, reset during RUN, and a full
// operand sweep with start held high. Expected results come from a
// behavioural model and are queued when a start is accepted.

module tb_seq_restoring_divider;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb[$];

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        if (b == 0) begin
            e.q  = '1;
            e.r  = a[W-1:0];
            e.dz = 1'b1;
        end else begin
            e.q  = W'(a / b);
            e.r  = W'(a % b);
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Launch one division from a negedge in IDLE/DONE and check it through
    // to its result. pulse=1 drops start after the accepting edge.
    // inject_at / reset_at name a RUN cycle index (0-based) or -1.
    task automatic do_op(input int a, input int b, input bit pulse,
                         input int inject_at, input int reset_at);
        exp_t e;
        logic [W-1:0] hq;
        logic [W-1:0] hr;
        start    = 1'b1;
        dividend = a[W-1:0];
        divisor  = b[W-1:0];
        @(posedge clk);
        sb.push_back(model(a, b));
        #1;
        if (pulse) start = 1'b0;
        // Operands must not matter once accepted.
        dividend = W'($urandom);
        divisor  = W'($urandom);
        if (b != 0) begin
            for (int i = 0; i < W; i++) begin
                @(negedge clk);
                check("busy_in_run", busy, 1);
                check("done_in_run", done, 0);
                if (i == reset_at) begin
                    #2 rst_n = 1'b0;
                    #1;
                    check("rst_busy", busy, 0);
                    check("rst_done", done, 0);
                    check("rst_div_zero", div_zero, 0);
                    check("rst_quotient", quotient, 0);
                    check("rst_remainder", remainder, 0);
                    start = 1'b0;
                    void'(sb.pop_back());
                    @(negedge clk);
                    rst_n = 1'b1;
                    repeat (W + 2) begin
                        @(negedge clk);
                        check("no_done_after_rst", done, 0);
                        check("no_busy_after_rst", busy, 0);
                    end
                    return;
                end
                if (i == inject_at) begin
                    start    = 1'b1;
                    dividend = 4'd9;
                    divisor  = 4'd2;
                    @(posedge clk);
                    #1;
                    start    = 1'b0;
                    dividend = W'($urandom);
                    divisor  = W'($urandom);
                end
            end
        end
        @(negedge clk);
        check("done_at_end", done, 1);
        check("busy_at_end", busy, 0);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check($sformatf("quotient_%0d/%0d", a, b), quotient, e.q);
            check($sformatf("remainder_%0d/%0d", a, b), remainder, e.r);
            check($sformatf("div_zero_%0d/%0d", a, b), div_zero, e.dz);
        end
        if (pulse) begin
            hq = quotient;
            hr = remainder;
            repeat (2) begin
                @(negedge clk);
                check("done_held", done, 1);
                check("quotient_held", quotient, e.q);
                check("remainder_held", remainder, e.r);
                check("busy_held_low", busy, 0);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_div_zero", div_zero, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);

        // Release at a negedge; the very next rising edge accepts the start.
        rst_n = 1'b1;
        do_op(13, 3, 1'b1, -1, -1);
        do_op(7, 0, 1'b1, -1, -1);
        do_op(2, 5, 1'b1, -1, -1);
        do_op(15, 1, 1'b1, -1, -1);

        // A start pulsed during RUN cycle 2 is ignored.
        do_op(13, 3, 1'b1, 1, -1);
        do_op(9, 2, 1'b1, -1, -1);

        // Reset during RUN cycle 3 abandons the operation.
        do_op(13, 3, 1'b1, -1, 2);
        do_op(14, 4, 1'b1, -1, -1);

        // Full sweep, start held high for back-to-back operation.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op(a, b, 1'b0, -1, -1);
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
